// File: rtl/rd_sched.sv
// -----------------------------------------------------------------------------
// rd_sched: read-side scheduler sharing one downstream consumer among NUM_CH
// FIFOs in the rclk domain. Non-empty channels are granted round-robin and
// popped in bursts of up to BURST_LEN words. Each popped word is captured in a
// single valid/ready output stage and tagged with its channel index.
//
// Ports:
//   rclk, rrst_n  - read-domain clock, asynchronous active-low reset
//   sched_en      - enables new grants and pops
//   ch_rempty     - per-channel empty flags
//   ch_rdata      - per-channel head words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_rinc       - per-channel pop strobe (one-hot or zero)
//   out_valid/out_ready/out_data/out_ch - output stage handshake, word and tag
//   sched_busy    - high while a burst grant is active
// -----------------------------------------------------------------------------
module rd_sched #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int CW         = $clog2(NUM_CH)
) (
    input  logic                         rclk,
    input  logic                         rrst_n,
    input  logic                         sched_en,
    input  logic [NUM_CH-1:0]            ch_rempty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
    output logic [NUM_CH-1:0]            ch_rinc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CW-1:0]                out_ch,
    output logic                         sched_busy
);

    localparam int CNTW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   init_cnt_r;
    logic [CW-1:0]          grant_r;
    logic [CW-1:0]          last_grant_r;
    logic [CNTW-1:0]        cnt_r;
    logic                   out_valid_r;
    logic [DATA_WIDTH-1:0]  out_data_r;
    logic [CW-1:0]          out_ch_r;

    logic [CW-1:0]          pick_s;
    logic                   pick_vld_s;
    logic                   grant_empty_s;
    logic [DATA_WIDTH-1:0]  grant_data_s;
    logic                   can_acc_s;
    logic                   pop_s;
    logic                   exit_s;

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;

    // Round-robin search: smallest distance from last_grant+1 among non-empty channels.
    always_comb begin
        int best_off;
        int off;
        pick_s     = '0;
        pick_vld_s = 1'b0;
        best_off   = NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
            off = (i + NUM_CH - 1 - int'(last_grant_r)) % NUM_CH;
            if (!ch_rempty[i] && (off < best_off)) begin
                best_off   = off;
                pick_s     = CW'(i);
                pick_vld_s = 1'b1;
            end else begin
                best_off   = best_off;
            end
        end
    end

    // Select the granted channel's empty flag and head word.
    always_comb begin
        grant_empty_s = 1'b1;
        grant_data_s  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_r == CW'(i)) begin
                grant_empty_s = ch_rempty[i];
                grant_data_s  = ch_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                grant_empty_s = grant_empty_s;
            end
        end
    end

    // A stalled output blocks both popping and leaving the burst.
    assign can_acc_s = !out_valid_r || out_ready;
    assign pop_s     = (state_r == ST_BURST) && can_acc_s && !grant_empty_s && sched_en;
    assign exit_s    = (pop_s && (cnt_r == CNTW'(BURST_LEN - 1)))
                     || ((state_r == ST_BURST) && can_acc_s && (grant_empty_s || !sched_en));

    // FSM state register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; INIT lasts two cycles and ignores the empty flags.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (sched_en && pick_vld_s) begin
                    state_nxt_s = ST_BURST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (exit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // FSM outputs: pop strobe for the granted channel and the busy flag.
    always_comb begin
        ch_rinc    = '0;
        sched_busy = (state_r == ST_BURST);
        for (int i = 0; i < NUM_CH; i++) begin
            if (pop_s && (grant_r == CW'(i))) begin
                ch_rinc[i] = 1'b1;
            end else begin
                ch_rinc[i] = 1'b0;
            end
        end
    end

    // Grant bookkeeping: INIT counter, current grant, burst count, last grant.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            init_cnt_r   <= 1'b0;
            grant_r      <= '0;
            last_grant_r <= CW'(NUM_CH - 1);
            cnt_r        <= '0;
        end else begin
            init_cnt_r <= (state_r == ST_INIT);
            if ((state_r == ST_IDLE) && sched_en && pick_vld_s) begin
                grant_r <= pick_s;
                cnt_r   <= '0;
            end else if (pop_s) begin
                cnt_r   <= cnt_r + CNTW'(1);
            end
            if (exit_s) begin
                last_grant_r <= grant_r;
            end
        end
    end

    // Output stage: load on pop, clear once accepted without a replacement.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
        end else if (pop_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_ch_r    <= grant_r;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: doc/rd_sched.md
# rd_sched

Read-side scheduler that shares one downstream consumer among `NUM_CH` asynchronous FIFOs, all read in the `rclk` domain. It arbitrates round-robin among non-empty channels and grants bursts of up to `BURST_LEN` words. It drives each FIFO's read-increment and registers the popped word into a single valid/ready output stage tagged with its channel index. It sits between the read controllers of the channel FIFOs and the common read-domain datapath.

## Interface
Parameters:
- `NUM_CH`, default 4: number of FIFO channels; must be ≥ 2.
- `DATA_WIDTH`, default 32: FIFO word width.
- `BURST_LEN`, default 4: maximum pops per grant; must be ≥ 1.
- `CW`, default `$clog2(NUM_CH)`: channel index width.

Ports:
- `rclk`, in, 1: read-domain clock.
- `rrst_n`, in, 1: reset, asynchronous, active-low. Clock is `rclk`.
- `sched_en`, in, 1: enables new grants.
- `ch_rempty`, in, `NUM_CH`: per-channel empty flag from each FIFO read controller.
- `ch_rdata`, in, `NUM_CH*DATA_WIDTH`: per-channel head word. Channel i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]` and is valid whenever `ch_rempty[i]` is 0.
- `ch_rinc`, out, `NUM_CH`: per-channel pop strobe. It is one-hot or zero.
- `out_valid`, out, 1: output word valid.
- `out_ready`, in, 1: consumer accepts the word.
- `out_data`, out, `DATA_WIDTH`: popped word.
- `out_ch`, out, `CW`: channel the word came from.
- `sched_busy`, out, 1: high in state BURST.

## Operation
- **FSM states:** INIT, IDLE, BURST. Registers:
  - `grant` (`CW` bits)
  - `last_grant` (`CW` bits)
  - `cnt` (`$clog2(BURST_LEN)` bits, minimum 1 bit)
  - output stage: `out_valid`, `out_data`, `out_ch`
- **INIT:** entered on reset. Holds exactly 2 `rclk` cycles after `rrst_n` deasserts, then moves to IDLE. While in INIT, `ch_rempty` is ignored because the empty flags are not trustworthy right after reset.
- **IDLE:**
  - If `sched_en` is 1 and any `ch_rempty` bit is 0, pick the first non-empty channel searching from `last_grant+1` upward, wrapping modulo `NUM_CH`.
  - On a pick: load `grant`, clear `cnt`, go to BURST. No pop occurs in the IDLE cycle.
- **BURST:**
  - `can_acc` = `!out_valid || out_ready`.
  - Pop condition: `can_acc && !ch_rempty[grant] && sched_en`.
    - On a pop: `ch_rinc[grant]` = 1 (combinational).
    - On the same edge: `out_data` ← `ch_rdata[grant]`, `out_ch` ← `grant`, `out_valid` ← 1, `cnt` ← `cnt+1`.
  - Exit to IDLE, with `last_grant` ← `grant`, when either:
    - a pop occurs with `cnt == BURST_LEN-1`; or
    - `can_acc` is 1 and (`ch_rempty[grant]` is 1 or `sched_en` is 0). No pop occurs on this cycle.
  - When `can_acc` is 0 (output stalled), BURST holds and no pop occurs, whatever the state of `ch_rempty`.
- **Output stage:** `out_valid` clears when `out_ready` is 1 and there is no pop in the same cycle. A word is never overwritten or dropped while `out_valid && !out_ready`.
- **`ch_rinc`:** 0 in every state other than BURST. At most one bit is set per cycle. A bit is never set for a channel whose `ch_rempty` is 1.
- **`cnt`:** wrap is not possible, because the exit happens on the pop that makes the count reach `BURST_LEN`. With `BURST_LEN=1` each grant pops exactly one word.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `out_ch`=0
  - `ch_rinc`=0, `sched_busy`=0
  - state=INIT
  - `last_grant`=`NUM_CH-1`, so the first search starts at channel 0
  - `grant`=0, `cnt`=0
- **Reset mid-burst:** all registers return to reset values immediately (asynchronous). `ch_rinc` drops to 0 in the same instant. A pending output word is discarded.
- **Latency:** a channel going non-empty while in IDLE gives:
  - grant on the next edge;
  - pop on the following cycle;
  - `out_valid` on the edge after that.
  
  Minimum latency is 2 cycles from IDLE-sample to `out_valid`.
- **Throughput:** 1 word/cycle within a burst when `out_ready` is held at 1. Each grant change costs exactly one idle cycle (the IDLE arbitration cycle).
- **Simultaneous events:**
  - An output word is accepted (`out_ready`) and a new pop happens on the same edge: `out_valid` stays at 1 and the new data replaces the old.
  - `sched_en` drops mid-burst: the current burst ends at the next `can_acc` cycle with no pop, and the already-registered word still drains.
  - A channel that goes empty and refills within a burst is served only while `ch_rempty` is 0 on pop cycles.

## Test plan
- **Reset/INIT:** all channels report non-empty (`ch_rempty`=0) from reset release, with `out_ready`=1.
  - `ch_rinc` must be 0 for exactly 2 cycles plus the IDLE cycle.
  - The first pop goes to channel 0 on cycle 4 after release.
  - `out_valid` rises on cycle 5 with `out_ch`=0.
- **Round-robin fairness:** `NUM_CH`=4, `BURST_LEN`=4, all channels full, `out_ready`=1.
  - Output `out_ch` sequence must be 0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0…
  - There must be exactly one bubble between groups.
- **Early exit on empty:** channel 1 holds 2 words, channel 2 holds 5 words, the others are empty.
  - Required output: two words with `out_ch`=1, then four with `out_ch`=2, then one with `out_ch`=2.
  - The order of data words must be preserved.
- **Backpressure:** hold `out_ready`=0 for 6 cycles mid-burst.
  - Exactly one pop occurs, then `ch_rinc` stays 0.
  - `out_data`/`out_ch` stay stable while `out_valid` is 1.
  - On release, the remaining `BURST_LEN-1` pops resume back-to-back with no word lost.
- **`sched_en` drop / async reset mid-burst:**
  - Deasserting `sched_en` after 2 pops ends the burst with no further pop. `sched_busy` falls on the next edge, and the registered word drains.
  - Asserting `rrst_n`=0 mid-burst forces `ch_rinc`=0 and `out_valid`=0 immediately. After release, INIT is re-run.
